// File: rtl/nv_ram_rwsp_160x16_pkg.sv
// Shared geometry and address helpers for the 160x16 read/write scratch RAM.
package nv_ram_rwsp_160x16_pkg;

  localparam int RAM_DEPTH    = 160;
  localparam int RAM_WIDTH    = 16;
  localparam int RAM_AW       = 8;
  localparam int RAM_LAST_ADR = 159;

  typedef logic [RAM_AW-1:0]    ram_adr_t;
  typedef logic [RAM_WIDTH-1:0] ram_word_t;

  // The 8-bit address space is wider than the array; anything above the
  // last entry is treated as "no such word".
  function automatic logic adr_in_range(input ram_adr_t adr);
    return (adr <= RAM_AW'(RAM_LAST_ADR));
  endfunction

endpackage

// File: rtl/nv_ram_array_160x16.sv
// Plain storage array: registered write, asynchronous read, no reset.
// Callers are responsible for keeping addresses in range.
module nv_ram_array_160x16
  import nv_ram_rwsp_160x16_pkg::*;
(
  input  logic      nvdla_core_clk_mgated,
  input  logic      we_i,
  input  ram_adr_t  wa_i,
  input  ram_word_t di_i,
  input  ram_adr_t  ra_i,
  output ram_word_t rdata_o
);

  ram_word_t mem_q [0:RAM_DEPTH-1];

  // Store the incoming word on a qualified write; contents survive reset.
  always_ff @(posedge nvdla_core_clk_mgated) begin
    if (we_i) begin
      mem_q[wa_i] <= di_i;
    end
  end

  // Combinational read returns the pre-edge contents, which is what gives
  // read-before-write behaviour when read and write hit the same entry.
  assign rdata_o = mem_q[ra_i];

endmodule

// File: rtl/nv_ram_rwsp_160x16.sv
// 160x16 RAM with one write port and a two-stage pipelined read port:
// re captures a word into rd_q, ore moves rd_q into the dout register.
module nv_ram_rwsp_160x16
  import nv_ram_rwsp_160x16_pkg::*;
#(
  parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic        nvdla_core_clk_mgated,
  input  logic        nvdla_core_rstn,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic [7:0]  wa,
  input  logic        we,
  input  logic [15:0] di,
  input  logic [7:0]  ra,
  input  logic        re,
  input  logic        ore,
  output logic [15:0] dout
);

  ram_word_t rd_q, rd_d;
  ram_word_t dout_q, dout_d;
  ram_word_t arr_rdata;
  logic      wa_ok, ra_ok, wr_en;

  // Power-down bus is reserved: kept as a port, deliberately unused.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign wa_ok = adr_in_range(wa);
  assign ra_ok = adr_in_range(ra);
  assign wr_en = we & wa_ok;

  nv_ram_array_160x16 u_array (
    .nvdla_core_clk_mgated (nvdla_core_clk_mgated),
    .we_i                  (wr_en),
    .wa_i                  (wa),
    .di_i                  (di),
    .ra_i                  (ra),
    .rdata_o               (arr_rdata)
  );

  // Next-state for both read stages; ore always sees the pre-edge rd_q so
  // re and ore together advance the pipeline by one word.
  always_comb begin
    rd_d   = rd_q;
    dout_d = dout_q;
    if (re) begin
      rd_d = ra_ok ? arr_rdata : '0;
    end
    if (ore) begin
      dout_d = rd_q;
    end
  end

  // Read pipeline registers; asynchronous reset clears any pending read.
  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

  // Simulation-only warning when a read and a write hit the same entry on
  // one edge; the client can mask it when it ignores that read.
  always_ff @(posedge nvdla_core_clk_mgated) begin
    if (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE == 1'b0 && nvdla_core_rstn) begin
      assert (!(wr_en && re && (wa == ra)))
        else $error("nv_ram_rwsp_160x16: read/write contention at address %0d", ra);
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_160x16.sv
// Self-checking bench for nv_ram_rwsp_160x16 against a word-level model.
module tb_nv_ram_rwsp_160x16;

  logic        clk;
  logic        rstn;
  logic [31:0] pwrbus_ram_pd;
  logic [7:0]  wa, ra;
  logic        we, re, ore;
  logic [15:0] di;
  logic [15:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory contents plus the two visible read stages.
  logic [15:0] m [0:159];
  logic [15:0] exp_rd;
  logic [15:0] exp_dout;

  nv_ram_rwsp_160x16 #(
    .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b1)
  ) dut (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .pwrbus_ram_pd         (pwrbus_ram_pd),
    .wa                    (wa),
    .we                    (we),
    .di                    (di),
    .ra                    (ra),
    .re                    (re),
    .ore                   (ore),
    .dout                  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive at negedge, update model at posedge, idle inputs after.
  task automatic step(input bit w, input int a_w, input logic [15:0] d,
                      input bit r, input int a_r, input bit o);
    @(negedge clk);
    we = w; wa = 8'(a_w); di = d; re = r; ra = 8'(a_r); ore = o;
    pwrbus_ram_pd = $urandom;
    @(posedge clk);
    if (o) exp_dout = exp_rd;
    if (r) exp_rd = (a_r < 160) ? m[a_r] : 16'h0000;
    if (w && a_w < 160) m[a_w] = d;
    #1;
    we = 1'b0; re = 1'b0; ore = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++; $display("FAIL reset_dout: got %h want 0000", dout);
    end
    @(negedge clk); rstn = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++; $display("FAIL reset_rd_q: got %h want 0000", dout);
    end
    $display("test_reset: dout=%h", dout);
  endtask

  task automatic test_basic();
    step(1, 5, 16'h1234, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h1234) begin
      n_bad++; $display("FAIL basic_read: got %h want 1234", dout);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (dout !== 16'h1234) begin
        n_bad++; $display("FAIL basic_hold: cycle %0d got %h want 1234", k, dout);
      end
    end
    $display("test_basic: dout=%h", dout);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 160; i++) step(1, i, 16'(i * 3), 0, 0, 0);
    for (int k = 0; k <= 160; k++) begin
      step(0, 0, 0, k < 160, k, k >= 1);
      if (k >= 1) begin
        n_cmp++;
        if (dout !== 16'((k - 1) * 3) || dout !== exp_dout) begin
          n_bad++; $display("FAIL sweep_stream: idx %0d got %h want %h", k - 1, dout, 16'((k - 1) * 3));
        end
      end
    end
    step(1, 0, 16'hC0DE, 0, 0, 0);
    for (int k = 0; k <= 3; k++) begin
      step(0, 0, 0, k < 3, k, k >= 1);
      if (k >= 1) begin
        n_cmp++;
        if (dout !== exp_dout) begin
          n_bad++; $display("FAIL sweep_rewrite: idx %0d got %h want %h", k - 1, dout, exp_dout);
        end
      end
    end
    $display("test_sweep: last dout=%h", dout);
  endtask

  task automatic test_stall();
    logic [15:0] held;
    step(1, 7, 16'h0077, 0, 0, 0);
    step(1, 8, 16'h0088, 0, 0, 0);
    held = exp_dout;
    step(0, 0, 0, 1, 7, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 8, 0);
      n_cmp++;
      if (dout !== held) begin
        n_bad++; $display("FAIL stall_hold: cycle %0d got %h want %h", k, dout, held);
      end
    end
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h0088) begin
      n_bad++; $display("FAIL stall_release: got %h want 0088", dout);
    end
    $display("test_stall: dout=%h", dout);
  endtask

  task automatic test_contention();
    step(1, 9, 16'hAAAA, 0, 0, 0);
    step(1, 9, 16'h5555, 1, 9, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'hAAAA) begin
      n_bad++; $display("FAIL contention_old: got %h want aaaa", dout);
    end
    step(0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h5555) begin
      n_bad++; $display("FAIL contention_new: got %h want 5555", dout);
    end
    $display("test_contention: dout=%h", dout);
  endtask

  task automatic test_out_of_range();
    step(1, 200, 16'hDEAD, 0, 0, 0);
    step(1, 255, 16'hBAD0, 0, 0, 0);
    for (int k = 0; k <= 160; k++) begin
      step(0, 0, 0, k < 160, k, k >= 1);
      if (k >= 1) begin
        n_cmp++;
        if (dout !== exp_dout) begin
          n_bad++; $display("FAIL oor_readback: idx %0d got %h want %h", k - 1, dout, exp_dout);
        end
      end
    end
    step(0, 0, 0, 1, 200, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++; $display("FAIL oor_read: got %h want 0000", dout);
    end
    $display("test_out_of_range: dout=%h", dout);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 199), 16'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 199), $urandom_range(0, 1));
      n_cmp++;
      if (dout !== exp_dout) begin
        n_bad++; errs++;
        $display("FAIL random_dout: step %0d got %h want %h", k, dout, exp_dout);
      end
    end
    $display("test_random: 400 steps, %0d errors", errs);
  endtask

  task automatic test_reset_midrun();
    step(1, 42, 16'hBEEF, 0, 0, 0);
    step(0, 0, 0, 1, 42, 0);
    step(0, 0, 0, 1, 43, 1);
    n_cmp++;
    if (dout !== 16'hBEEF) begin
      n_bad++; $display("FAIL midreset_pre: got %h want beef", dout);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++; $display("FAIL midreset_async: got %h want 0000", dout);
    end
    exp_rd = 16'h0000; exp_dout = 16'h0000;
    @(negedge clk); rstn = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++; $display("FAIL midreset_pending: got %h want 0000", dout);
    end
    step(0, 0, 0, 1, 42, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dout !== 16'hBEEF) begin
      n_bad++; $display("FAIL midreset_keep: got %h want beef", dout);
    end
    $display("test_reset_midrun: dout=%h", dout);
  endtask

  initial begin
    rstn = 1'b0; we = 1'b0; re = 1'b0; ore = 1'b0;
    wa = '0; ra = '0; di = '0; pwrbus_ram_pd = '0;
    exp_rd = 16'h0000; exp_dout = 16'h0000;
    for (int i = 0; i < 160; i++) m[i] = 16'h0000;
    test_reset();
    test_basic();
    test_sweep();
    test_stall();
    test_contention();
    test_out_of_range();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
